// File: rtl/rv32i_types.sv
// Shared types for the memory-side blocks: the 32-bit word used for
// addresses and the state encoding of the line arbiter.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_XFER,
        ARB_DONE
    } arb_state_t;

endpackage

// File: rtl/line_burst_adaptor.sv
// Serialises one cache line into BURST_W beats and assembles read beats back
// into a line. A single line register serves both directions: it is loaded
// with the write line at grant, or filled slice by slice on a read.
module line_burst_adaptor #(
    parameter int LINE_W  = 256,
    parameter int BURST_W = 64
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_i,        // grant cycle: clear beat counter
    input  logic               load_write_i,  // grant of a write: capture line
    input  logic [LINE_W-1:0]  wline_i,
    input  logic               active_i,      // transfer in progress
    input  logic               is_read_i,
    input  logic               mem_resp_i,
    input  logic [BURST_W-1:0] mem_rdata_i,
    output logic [BURST_W-1:0] mem_wdata_o,
    output logic [LINE_W-1:0]  line_o,
    output logic               last_beat_o
);

    localparam int BEATS = LINE_W / BURST_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    logic [CNT_W-1:0]  beat_q, beat_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic              beat_ack;

    // mem_resp only counts while a transfer is active
    assign beat_ack    = active_i & mem_resp_i;
    assign last_beat_o = beat_ack && (beat_q == LAST_BEAT);
    assign mem_wdata_o = line_q[beat_q*BURST_W +: BURST_W];
    assign line_o      = line_q;

    // Next-state for beat counter and line register
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        beat_d = beat_q;
        line_d = line_q;
        if (load_i) begin
            beat_d = '0;
            if (load_write_i) begin
                line_d = wline_i;
            end
        end else if (beat_ack) begin
            if (is_read_i) begin
                line_d[beat_q*BURST_W +: BURST_W] = mem_rdata_i;
            end
            beat_d = (beat_q == LAST_BEAT) ? '0 : beat_q + 1'b1;
        end
    end

    // Beat counter and line register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_q <= '0;
            // NOTE: this wide register is reset because req_rdata and mem_wdata must read as zero during reset.
            line_q <= '0;
        end else begin
            beat_q <= beat_d;
            line_q <= line_d;
        end
    end

endmodule

// File: rtl/rr_mem_arbiter.sv
// Round-robin arbiter of NUM_PORTS cache-line requesters onto one burst
// memory port; one line transaction in flight, priority rotates after each.
// Build option: define ARB_FIXED_PRIO_EN to pin the priority pointer at port 0
// (lowest-index requester always wins).
module rr_mem_arbiter
    import rv32i_types::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int LINE_W    = 256,
    parameter int BURST_W   = 64
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  rv32i_word [NUM_PORTS-1:0]        req_addr,
    input  logic      [NUM_PORTS-1:0]        req_read,
    input  logic      [NUM_PORTS-1:0]        req_write,
    input  logic      [NUM_PORTS-1:0][LINE_W-1:0] req_wdata,
    output logic      [LINE_W-1:0]           req_rdata,
    output logic      [NUM_PORTS-1:0]        req_resp,
    output rv32i_word                        mem_addr,
    output logic                             mem_read,
    output logic                             mem_write,
    output logic      [BURST_W-1:0]          mem_wdata,
    input  logic      [BURST_W-1:0]          mem_rdata,
    input  logic                             mem_resp
);

    localparam int        IDX_W     = $clog2(NUM_PORTS);
    localparam int        OFS       = $clog2(LINE_W / 8);
    localparam rv32i_word ADDR_MASK = ~rv32i_word'((1 << OFS) - 1);

    arb_state_t           state_q;
    logic [IDX_W-1:0]     grant_q;
    rv32i_word            addr_q;
    logic                 is_read_q;
    logic                 mem_read_q;
    logic                 mem_write_q;
    logic [NUM_PORTS-1:0] resp_q;

    logic [NUM_PORTS-1:0] cand;
    logic [IDX_W-1:0]     rr_ptr;
    logic [IDX_W-1:0]     idx;
    logic [IDX_W-1:0]     pick;
    logic                 any_cand;
    logic                 load;
    logic                 load_write;
    logic                 last_beat;

    assign cand = req_read | req_write;

    // First candidate at or after rr_ptr, wrapping around the port list
    always_comb begin
        idx      = '0;
        pick     = '0;
        any_cand = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            idx = IDX_W'((int'(rr_ptr) + i) % NUM_PORTS);
            if (!any_cand && cand[idx]) begin
                any_cand = 1'b1;
                pick     = idx;
            end
        end
    end

`ifdef ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [IDX_W-1:0] rr_ptr_q;

    // Rotate priority to the port after the one just served
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q <= '0;
        end else if (state_q == ARB_DONE) begin
            rr_ptr_q <= (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
        end
    end

    assign rr_ptr = rr_ptr_q;
`endif

    // A port raising read and write together is served as a read
    assign load       = (state_q == ARB_IDLE) && any_cand;
    assign load_write = load && !req_read[pick];

    // Transaction FSM: grant, hold burst request, pulse completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            addr_q      <= '0;
            is_read_q   <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            resp_q      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            resp_q <= '0;
            unique case (state_q)
                ARB_IDLE: begin
                    if (any_cand) begin
                        state_q     <= ARB_XFER;
                        grant_q     <= pick;
                        addr_q      <= req_addr[pick];
                        is_read_q   <= req_read[pick];
                        mem_read_q  <= req_read[pick];
                        mem_write_q <= !req_read[pick];
                    end
                end
                ARB_XFER: begin
                    if (last_beat) begin
                        state_q     <= ARB_DONE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        resp_q      <= NUM_PORTS'(1) << grant_q;
                    end
                end
                ARB_DONE: state_q <= ARB_IDLE;
                default:  state_q <= ARB_IDLE;
            endcase
        end
    end

    line_burst_adaptor #(
        .LINE_W  (LINE_W),
        .BURST_W (BURST_W)
    ) u_adaptor (
        .clk          (clk),
        .reset_n      (reset_n),
        .load_i       (load),
        .load_write_i (load_write),
        .wline_i      (req_wdata[pick]),
        .active_i     (state_q == ARB_XFER),
        .is_read_i    (is_read_q),
        .mem_resp_i   (mem_resp),
        .mem_rdata_i  (mem_rdata),
        .mem_wdata_o  (mem_wdata),
        .line_o       (req_rdata),
        .last_beat_o  (last_beat)
    );

    assign mem_addr  = addr_q & ADDR_MASK;
    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign req_resp  = resp_q;

endmodule

// File: tb/tb_rr_mem_arbiter.sv
// Self-checking bench for rr_mem_arbiter with four ports: directed single
// transactions, reset during a burst, randomized multi-port traffic against a
// transaction-level model, and a saturated round-robin run.
module tb_rr_mem_arbiter;

    localparam int NP      = 4;
    localparam int LINE_W  = 256;
    localparam int BURST_W = 64;
    localparam int BEATS   = LINE_W / BURST_W;
    localparam logic [31:0] LINE_MASK = ~32'(LINE_W / 8 - 1);

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic [NP-1:0][31:0]      req_addr;
    logic [NP-1:0]            req_read;
    logic [NP-1:0]            req_write;
    logic [NP-1:0][LINE_W-1:0] req_wdata;
    logic [LINE_W-1:0]        req_rdata;
    logic [NP-1:0]            req_resp;
    logic [31:0]              mem_addr;
    logic                     mem_read;
    logic                     mem_write;
    logic [BURST_W-1:0]       mem_wdata;
    logic [BURST_W-1:0]       mem_rdata;
    logic                     mem_resp;

    int n_checks = 0;
    int n_pass   = 0;
    int m_ptr    = 0;
    int grant_log[$];
    int resp_cnt[NP];

    rr_mem_arbiter #(
        .NUM_PORTS (NP),
        .LINE_W    (LINE_W),
        .BURST_W   (BURST_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_addr  (req_addr),
        .req_read  (req_read),
        .req_write (req_write),
        .req_wdata (req_wdata),
        .req_rdata (req_rdata),
        .req_resp  (req_resp),
        .mem_addr  (mem_addr),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_resp  (mem_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] l = '0;
        for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
        return l;
    endfunction

    function automatic logic [NP-1:0] onehot(input int p);
        logic [NP-1:0] v = '0;
        v[p] = 1'b1;
        return v;
    endfunction

    // Priority after serving port g
    function automatic int next_ptr(input int g);
        int p = (g + 1) % NP;
`ifdef ARB_FIXED_PRIO_EN
        p = 0;
`endif
        return p;
    endfunction

    // First requesting port at or after ptr, wrapping
    function automatic int model_pick(input logic [NP-1:0] pend, input int ptr);
        for (int i = 0; i < NP; i++) begin
            if (pend[(ptr + i) % NP]) return (ptr + i) % NP;
        end
        return -1;
    endfunction

    task automatic clear_inputs();
        req_read  = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        mem_resp  = 1'b0;
        mem_rdata = '0;
    endtask

    task automatic apply_reset();
        reset_n = 1'b0;
        clear_inputs();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        m_ptr   = 0;
    endtask

    // One transaction on port p with a fixed stall before every beat.
    // For reads, line supplies the beats; for writes it is the line to send.
    task automatic run_single(input int p, input bit wr, input logic [31:0] addr,
                              input logic [LINE_W-1:0] line, input int stall);
        int cyc   = 0;
        int beat  = 0;
        int wcnt  = 0;
        bit seen  = 1'b0;
        bit done  = 1'b0;
        req_addr[p]  = addr;
        req_wdata[p] = line;
        req_read[p]  = !wr;
        req_write[p] = wr;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            mem_resp = 1'b0;
            if (req_resp != '0) begin
                check("single_resp_port", req_resp, onehot(p));
                check("single_latency", cyc, BEATS * (stall + 1) + 1);
                if (!wr) check("single_rdata", req_rdata, line);
                done = 1'b1;
            end else if (mem_read | mem_write) begin
                if (!seen) begin
                    check("single_start_cycle", cyc, 1);
                    check("single_addr", mem_addr, addr & LINE_MASK);
                    check("single_op", {mem_read, mem_write}, {!wr, wr});
                    seen = 1'b1;
                end
                // Granted inputs are latched; disturbing them must not matter
                req_addr[p]  = $urandom;
                req_wdata[p] = rand_line();
                if (wcnt < stall) begin
                    wcnt++;
                end else if (beat < BEATS) begin
                    wcnt     = 0;
                    mem_resp = 1'b1;
                    if (wr) check("single_wbeat", mem_wdata, line[beat*BURST_W +: BURST_W]);
                    else    mem_rdata = line[beat*BURST_W +: BURST_W];
                    beat++;
                end
            end
        end
        check("single_done", done, 1'b1);
        req_read[p]  = 1'b0;
        req_write[p] = 1'b0;
        mem_resp     = 1'b0;
        @(negedge clk);
        check("single_pulse_end", {mem_read, mem_write, req_resp}, '0);
        m_ptr = next_ptr(p);
    endtask

    // Random multi-port traffic checked at transaction level.
    // pct: chance (percent) an idle port raises a request each cycle.
    task automatic run_loop(input int n_txn, input int pct, input int stall_max);
        logic [NP-1:0]     pend = '0;
        int                m_op[NP];      // 0 read, 1 write, 2 read+write
        logic [31:0]       m_addr[NP];
        logic [LINE_W-1:0] m_line[NP];
        logic [LINE_W-1:0] rd_line = '0;
        logic [1:0]        exp_op;
        int g = 0, beats = 0, done_txn = 0, guard = 0, released;
        bit active = 1'b0, resp_due = 1'b0, gap = 1'b0, grant_due = 1'b0;
        bit in_idle, busy;
        while (done_txn < n_txn && guard < 20000) begin
            @(negedge clk);
            guard++;
            busy     = mem_read | mem_write;
            in_idle  = 1'b0;
            released = -1;
            exp_op   = (m_op[g] == 1) ? 2'b01 : 2'b10;
            if (resp_due) begin
                check("resp_port", {busy, req_resp}, {1'b0, onehot(g)});
                if (m_op[g] != 1) check("resp_rdata", req_rdata, rd_line);
                resp_cnt[g]++;
                pend[g]      = 1'b0;
                req_read[g]  = 1'b0;
                req_write[g] = 1'b0;
                released     = g;
                m_ptr        = next_ptr(g);
                active       = 1'b0;
                resp_due     = 1'b0;
                gap          = 1'b1;
                done_txn++;
            end else if (gap) begin
                check("gap_idle", {busy, req_resp}, '0);
                gap     = 1'b0;
                in_idle = 1'b1;
            end else if (!active) begin
                if (grant_due) begin
                    g      = model_pick(pend, m_ptr);
                    exp_op = (m_op[g] == 1) ? 2'b01 : 2'b10;
                    check("grant_op", {mem_read, mem_write}, exp_op);
                    check("grant_addr", mem_addr, m_addr[g] & LINE_MASK);
                    grant_log.push_back(g);
                    active  = 1'b1;
                    beats   = 0;
                    rd_line = '0;
                end else begin
                    check("idle_quiet", {busy, req_resp}, '0);
                    in_idle = 1'b1;
                end
            end else begin
                check("xfer_hold", {mem_read, mem_write, req_resp}, {exp_op, {NP{1'b0}}});
            end

            // Memory side: random stalls while busy, noise while not
            mem_resp = 1'b0;
            if (active && !resp_due) begin
                if ($urandom_range(0, stall_max) == 0) begin
                    mem_resp = 1'b1;
                    if (m_op[g] == 1) begin
                        check("wr_beat", mem_wdata, m_line[g][beats*BURST_W +: BURST_W]);
                    end else begin
                        mem_rdata = {$urandom, $urandom};
                        rd_line[beats*BURST_W +: BURST_W] = mem_rdata;
                    end
                    beats++;
                    if (beats == BEATS) resp_due = 1'b1;
                end
            end else begin
                mem_resp  = ($urandom_range(0, 1) == 1);
                mem_rdata = {$urandom, $urandom};
            end

            // Requesters
            for (int p = 0; p < NP; p++) begin
                if (active && p == g) begin
                    req_addr[p]  = $urandom;
                    req_wdata[p] = rand_line();
                end else if (!pend[p] && p != released && $urandom_range(1, 100) <= pct) begin
                    pend[p]      = 1'b1;
                    m_op[p]      = $urandom_range(0, 2);
                    m_addr[p]    = $urandom;
                    m_line[p]    = rand_line();
                    req_read[p]  = (m_op[p] != 1);
                    req_write[p] = (m_op[p] != 0);
                    req_addr[p]  = m_addr[p];
                    req_wdata[p] = m_line[p];
                end
            end
            grant_due = in_idle && (pend != '0);
        end
        req_read  = '0;
        req_write = '0;
        mem_resp  = 1'b0;
        check("loop_done", done_txn, n_txn);
        if (done_txn < n_txn) begin
            apply_reset();
        end else begin
            @(negedge clk);
            check("loop_tail_idle", {mem_read, mem_write, req_resp}, '0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        clear_inputs();

        // Reset values
        @(negedge clk);
        check("reset_mem_read", mem_read, 1'b0);
        check("reset_mem_write", mem_write, 1'b0);
        check("reset_req_resp", req_resp, '0);
        check("reset_mem_addr", mem_addr, '0);
        check("reset_mem_wdata", mem_wdata, '0);
        check("reset_req_rdata", req_rdata, '0);
        apply_reset();

        // Single read on port 1, zero-wait memory
        run_single(1, 1'b0, 32'h0000_1234,
                   {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                    64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 0);
        // Single write on port 0
        run_single(0, 1'b1, 32'h0000_0080, rand_line(), 0);
        // Read with three stall cycles before every beat
        run_single(2, 1'b0, $urandom, rand_line(), 3);

        // Reset asserted mid-burst
        req_read[3] = 1'b1;
        req_addr[3] = 32'h0000_4000;
        @(negedge clk);
        check("rst_pre_busy", mem_read, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_mem_write", mem_write, 1'b0);
        check("rst_req_resp", req_resp, '0);
        check("rst_mem_addr", mem_addr, '0);
        check("rst_mem_wdata", mem_wdata, '0);
        check("rst_req_rdata", req_rdata, '0);
        @(negedge clk);
        reset_n = 1'b1;
        m_ptr   = 0;
        @(negedge clk);
        check("rst_restart_read", mem_read, 1'b1);
        check("rst_restart_addr", mem_addr, 32'h0000_4000);
        apply_reset();

        // Randomized contention with memory stalls
        run_loop(40, 40, 2);

        // Saturated round robin from reset, zero-wait memory
        apply_reset();
        grant_log.delete();
        foreach (resp_cnt[p]) resp_cnt[p] = 0;
        run_loop(8, 100, 0);
        check("rr_count", grant_log.size(), 8);
        for (int i = 0; i < 8 && i < grant_log.size(); i++) begin
`ifdef ARB_FIXED_PRIO_EN
            check("rr_order", grant_log[i], 0);
`else
            check("rr_order", grant_log[i], i % NP);
`endif
        end
        for (int p = 0; p < NP; p++) begin
`ifdef ARB_FIXED_PRIO_EN
            check("rr_resp_per_port", resp_cnt[p], (p == 0) ? 8 : 0);
`else
            check("rr_resp_per_port", resp_cnt[p], 2);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_mem_arbiter.md
# rr_mem_arbiter

Parametrised round-robin arbiter that multiplexes NUM_PORTS cache-line requesters (I-cache, D-cache, prefetcher, etc.) onto one burst-oriented physical-memory port. It replaces the fixed two-client instruction/data arbiter and absorbs the line-to-burst serialisation, so it sits between the L1/L2 caches and the memory model. One line transaction is in flight at a time. The granted port is held until its transaction completes, and priority then rotates.

## Interface
- NUM_PORTS, default 2: number of requesters; valid range 2..8.
- LINE_W, default 256: cache-line width in bits.
- BURST_W, default 64: memory beat width; LINE_W must be a multiple of BURST_W.
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_addr  in  NUM_PORTS x 32  per-port line address.
- req_read  in  NUM_PORTS  per-port line read request, level.
- req_write  in  NUM_PORTS  per-port line write request, level.
- req_wdata  in  NUM_PORTS x LINE_W  per-port write line.
- req_rdata  out  LINE_W  shared read line; valid when the matching resp is high.
- req_resp  out  NUM_PORTS  per-port one-cycle completion pulse.
- mem_addr  out  32  line-aligned burst address.
- mem_read  out  1  burst read request.
- mem_write  out  1  burst write request.
- mem_wdata  out  BURST_W  current write beat.
- mem_rdata  in  BURST_W  current read beat.
- mem_resp  in  1  beat acknowledge.

## Operation
- BEATS = LINE_W/BURST_W. OFS = log2(LINE_W/8).
- State IDLE:
  - Any port with req_read or req_write high is a candidate.
  - Select the first candidate at or after rr_ptr, wrapping modulo NUM_PORTS.
  - Latch grant index g, address, opcode and write line.
  - Go to XFER. If there are no candidates, stay in IDLE.
- Read and write asserted together on one port: treated as a read.
- State XFER:
  - mem_addr = {latched addr[31:OFS], OFS zeros}.
  - Hold mem_read or mem_write high continuously.
  - Beat counter k starts at 0.
  - Write: mem_wdata = line[k*BURST_W +: BURST_W].
  - Read: on each mem_resp, store mem_rdata into line slice k.
  - k increments on each mem_resp. On the beat where k = BEATS-1, go to DONE.
- State DONE:
  - req_resp[g] = 1 for exactly one cycle; req_rdata = assembled line.
  - rr_ptr <= (g+1) mod NUM_PORTS.
  - Next state IDLE.
- req_resp is never asserted for a non-granted port.
- Inputs of the granted port are latched at grant; changes during XFER are ignored.
- Requester contract: deassert the request in the cycle after req_resp. IDLE samples in that cycle, so a still-asserted request is treated as a new transaction.

## Timing
- Reset (async, reset_n low): state IDLE, rr_ptr 0, k 0. mem_read, mem_write, req_resp, mem_addr, mem_wdata and req_rdata are all 0.
- Reset released mid-burst: the transaction is abandoned and no resp is issued.
- All outputs are registered-state decoded. There is no combinational path from req_* to mem_*.
- Latency: request high in IDLE at edge n → mem_read/mem_write high from cycle n+1.
- With zero-wait memory (mem_resp every cycle): mem_* high for BEATS cycles, then req_resp in cycle n+1+BEATS.
- Total: BEATS+2 cycles from request to resp, plus memory wait cycles.
- Back-to-back: the next grant is earliest 1 cycle after DONE (one IDLE cycle between transactions).
- mem_resp in IDLE or DONE is ignored.

## Configuration
- ARB_FIXED_PRIO_EN defined: rr_ptr is tied to 0. The lowest-index candidate always wins (port 0 = I-cache).
- ARB_FIXED_PRIO_EN undefined: round-robin as described under Operation.

## Structure
- Package rv32i_types (shared) holds:
  - arb_state_t enum {ARB_IDLE, ARB_XFER, ARB_DONE};
  - rv32i_word, for the address ports.
- Sub-module line_burst_adaptor (parametrised LINE_W/BURST_W) holds:
  - beat counter;
  - read-line assembly register;
  - write-beat mux;
  - last-beat flag.
- rr_mem_arbiter keeps the grant logic, rr_ptr and the state machine.

## Test plan
- Reset: assert reset_n=0 mid-XFER → all outputs 0 immediately. After release, the first request gets mem_read the next cycle.
- Single read, defaults: port 1 reads 0x0000_1234 with zero-wait memory and beats 0x11..,0x22..,0x33..,0x44.. → mem_addr 0x0000_1220. req_resp[1] in cycle 6 with line {0x44..,0x33..,0x22..,0x11..}.
- Write: port 0 writes line L to 0x80 → mem_wdata shows L[63:0], L[127:64], L[191:128], L[255:192] on successive mem_resp beats. req_resp[0] pulses once.
- Round robin, NUM_PORTS=4: all ports request continuously with zero-wait memory → grants in order 0,1,2,3,0. Each port gets exactly one resp per 4 transactions.
- ARB_FIXED_PRIO_EN defined, ports 0 and 2 both requesting → port 0 is granted. Port 2 is granted only after port 0 deasserts.
- Wait states: mem_resp held low 3 cycles between beats → mem_read stays high and the line is assembled correctly. Resp latency grows by 3 cycles per stall.
